// File: rtl/recevier_burst_gen_pkg.sv
// Shared types and helpers for the recevier burst generator.
//   resp_state_t   : IDLE / ACTIVE state encoding
//   clamp_len()    : maps a requested length onto [min_len, max_len]
//   len_params_ok(): legality of the MIN_LEN / MAX_LEN parameter pair
package resp_pkg;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} resp_state_t;

    localparam int RUN_MAX = 15;

    // A request length of 0 naturally lands on min_len because min_len >= 1.
    function automatic int clamp_len(input int req, input int min_len, input int max_len);
        if (req < min_len) begin
            return min_len;
        end
        if (req > max_len) begin
            return max_len;
        end
        return req;
    endfunction

    function automatic bit len_params_ok(input int min_len, input int max_len);
        return (min_len >= 1) && (min_len <= max_len);
    endfunction

endpackage

// File: rtl/recevier_burst_gen_sat_counter.sv
// Saturating event counter.
//   clk : clock
//   rst : synchronous active-high reset (highest priority)
//   clr : synchronous clear, wins over inc
//   inc : count one event; holds at all-ones
//   q   : count value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (inc && (q_reg != '1)) begin
            q_reg <= q_reg + W'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/recevier_burst_gen.sv
// Request-driven burst generator: each accepted transmiter request drives
// recevier high for L = clamp(req_len, MIN_LEN, MAX_LEN) cycles starting one
// cycle later; overlapping requests extend (never queue) the burst.
//   clk, rst           : clock, synchronous active-high reset
//   en, transmiter     : request enable and request strobe
//   req_len            : requested burst length
//   clr_cnt            : clear statistics counters
//   recevier, busy     : registered response strobe (identical)
//   burst_done         : one-cycle pulse on first low cycle after a burst
//   run_len            : current run length of recevier, saturating at 15
//   req_cnt, extend_cnt, burst_cnt, drop_cnt : saturating statistics
module recevier_burst_gen
    import resp_pkg::*;
#(
    parameter int LEN_W   = 2,
    parameter int MIN_LEN = 2,
    parameter int MAX_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             transmiter,
    input  logic [LEN_W-1:0] req_len,
    input  logic             clr_cnt,
    output logic             recevier,
    output logic             busy,
    output logic             burst_done,
    output logic [3:0]       run_len,
    output logic [CNT_W-1:0] req_cnt,
    output logic [CNT_W-1:0] extend_cnt,
    output logic [CNT_W-1:0] burst_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int REM_W = $clog2(MAX_LEN + 1);

    generate
        if (!len_params_ok(MIN_LEN, MAX_LEN)) begin : g_bad_len
            $error("recevier_burst_gen: need 1 <= MIN_LEN <= MAX_LEN");
        end
    endgenerate

    resp_state_t      state_reg;
    logic [REM_W-1:0] rem_reg;
    logic [REM_W-1:0] rem_dec;
    logic [REM_W-1:0] rem_next;
    logic [REM_W-1:0] len_eff;
    logic             accept;
    logic             done_next;
    logic             done_reg;
    logic [3:0]       run_len_reg;
    logic [3:0]       run_len_next;

    always_comb begin
        accept    = transmiter & en;
        len_eff   = REM_W'(clamp_len(int'(req_len), MIN_LEN, MAX_LEN));
        rem_dec   = (rem_reg != '0) ? rem_reg - REM_W'(1) : '0;
        // A request only ever raises the remaining count to L; it never adds.
        rem_next  = rem_dec;
        if (accept && (len_eff > rem_dec)) begin
            rem_next = len_eff;
        end
        // Last high cycle with nothing extending it.
        done_next = (rem_reg == REM_W'(1)) && !accept;
        run_len_next = 4'd0;
        if (rem_next != '0) begin
            run_len_next = (run_len_reg == 4'(RUN_MAX)) ? 4'(RUN_MAX) : run_len_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            done_reg    <= 1'b0;
            run_len_reg <= 4'd0;
        end else begin
            rem_reg     <= rem_next;
            done_reg    <= done_next;
            run_len_reg <= run_len_next;
            case (state_reg)
                IDLE:    if (accept)            state_reg <= ACTIVE;
                ACTIVE:  if (rem_next == '0)    state_reg <= IDLE;
                default:                        state_reg <= IDLE;
            endcase
        end
    end

    assign recevier   = (state_reg == ACTIVE);
    assign busy       = recevier;
    assign burst_done = done_reg;
    assign run_len    = run_len_reg;

    // Counter order: 0 req, 1 extend, 2 burst, 3 drop.
    logic [3:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_q [4];

    assign cnt_inc[0] = accept;
    assign cnt_inc[1] = accept && (rem_dec != '0);
    assign cnt_inc[2] = done_next;
    assign cnt_inc[3] = transmiter & ~en;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .clr (clr_cnt),
                .inc (cnt_inc[gi]),
                .q   (cnt_q[gi])
            );
        end
    endgenerate

    assign req_cnt    = cnt_q[0];
    assign extend_cnt = cnt_q[1];
    assign burst_cnt  = cnt_q[2];
    assign drop_cnt   = cnt_q[3];

endmodule

// File: tb/tb_recevier_burst_gen.sv
module tb_recevier_burst_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       transmiter = 1'b0;
    logic [2:0] req_len = 3'd0;
    logic       clr_cnt = 1'b0;
    logic       recevier, busy, burst_done;
    logic [3:0] run_len;
    logic [1:0] req_cnt, extend_cnt, burst_cnt, drop_cnt;

    always #5 clk = ~clk;

    recevier_burst_gen #(
        .LEN_W(3), .MIN_LEN(2), .MAX_LEN(3), .CNT_W(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .transmiter (transmiter),
        .req_len    (req_len),
        .clr_cnt    (clr_cnt),
        .recevier   (recevier),
        .busy       (busy),
        .burst_done (burst_done),
        .run_len    (run_len),
        .req_cnt    (req_cnt),
        .extend_cnt (extend_cnt),
        .burst_cnt  (burst_cnt),
        .drop_cnt   (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst, en, tx, clr;
        logic [2:0] len;
        logic       rcv, done;
        logic [3:0] run;
        logic [1:0] req, ext, bur, drp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input int r, input int e, input int t, input int l, input int c,
                       input int rc, input int dn, input int rn,
                       input int rq, input int ex, input int bu, input int dr);
        vec_t v;
        v.rst = 1'(r);  v.en = 1'(e);   v.tx = 1'(t);   v.len = 3'(l); v.clr = 1'(c);
        v.rcv = 1'(rc); v.done = 1'(dn); v.run = 4'(rn);
        v.req = 2'(rq); v.ext = 2'(ex); v.bur = 2'(bu); v.drp = 2'(dr);
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Property monitor: every accepted request must be followed by at least
    // MIN_LEN (2) consecutive high cycles of recevier, starting next cycle.
    int need = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            need = 0;
        end else begin
            if (transmiter && en && need < 2) need = 2;
            if (need > 0) begin
                checks++;
                if (!recevier) begin
                    errors++;
                    $display("FAIL prop_burst at %0t: recevier got 0 expected 1", $time);
                end
                need--;
            end
        end
    end

    initial begin
        //   rst en tx len clr | rcv done run req ext bur drp
        add(1, 1, 1, 3, 0,   0, 0, 0, 0, 0, 0, 0); // request during reset ignored
        add(0, 1, 1, 2, 0,   1, 0, 1, 1, 0, 0, 0); // single request, L=2
        add(0, 1, 0, 2, 0,   1, 0, 2, 1, 0, 0, 0);
        add(0, 1, 0, 2, 0,   0, 1, 0, 1, 0, 1, 0);
        add(0, 1, 0, 2, 0,   0, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0); // clear
        add(0, 1, 1, 0, 0,   1, 0, 1, 1, 0, 0, 0); // req_len 0 -> 2
        add(0, 1, 0, 0, 0,   1, 0, 2, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0,   0, 1, 0, 1, 0, 1, 0);
        add(0, 1, 1, 3, 0,   1, 0, 1, 2, 0, 1, 0); // req_len 3 -> 3
        add(0, 1, 0, 0, 0,   1, 0, 2, 2, 0, 1, 0);
        add(0, 1, 0, 0, 0,   1, 0, 3, 2, 0, 1, 0);
        add(0, 1, 0, 0, 0,   0, 1, 0, 2, 0, 2, 0);
        add(0, 1, 1, 7, 0,   1, 0, 1, 3, 0, 2, 0); // req_len 7 -> 3
        add(0, 1, 0, 0, 0,   1, 0, 2, 3, 0, 2, 0);
        add(0, 1, 0, 0, 0,   1, 0, 3, 3, 0, 2, 0);
        add(0, 1, 0, 0, 0,   0, 1, 0, 3, 0, 3, 0);
        add(0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 2, 0,   1, 0, 1, 1, 0, 0, 0); // back-to-back x3, L=2
        add(0, 1, 1, 2, 0,   1, 0, 2, 2, 1, 0, 0);
        add(0, 1, 1, 2, 0,   1, 0, 3, 3, 2, 0, 0);
        add(0, 1, 0, 2, 0,   1, 0, 4, 3, 2, 0, 0);
        add(0, 1, 0, 2, 0,   0, 1, 0, 3, 2, 1, 0);
        add(0, 1, 0, 2, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 2, 0,   0, 0, 0, 0, 0, 0, 1); // dropped request
        add(0, 1, 1, 3, 0,   1, 0, 1, 1, 0, 0, 1); // en falls mid-burst
        add(0, 1, 0, 3, 0,   1, 0, 2, 1, 0, 0, 1);
        add(0, 0, 1, 3, 0,   1, 0, 3, 1, 0, 0, 2);
        add(0, 0, 0, 3, 0,   0, 1, 0, 1, 0, 1, 2);
        add(0, 1, 0, 3, 1,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 3, 0,   1, 0, 1, 1, 0, 0, 0); // overlap does not lengthen
        add(0, 1, 1, 2, 0,   1, 0, 2, 2, 1, 0, 0);
        add(0, 1, 0, 2, 0,   1, 0, 3, 2, 1, 0, 0);
        add(0, 1, 0, 2, 0,   0, 1, 0, 2, 1, 1, 0);
        add(0, 1, 1, 2, 0,   1, 0, 1, 3, 1, 1, 0); // request on last high cycle
        add(0, 1, 0, 2, 0,   1, 0, 2, 3, 1, 1, 0);
        add(0, 1, 1, 2, 0,   1, 0, 3, 3, 1, 1, 0);
        add(0, 1, 0, 2, 0,   1, 0, 4, 3, 1, 1, 0);
        add(0, 1, 0, 2, 0,   0, 1, 0, 3, 1, 2, 0);
        add(0, 1, 1, 3, 0,   1, 0, 1, 3, 1, 2, 0); // reset mid-burst
        add(0, 1, 0, 3, 0,   1, 0, 2, 3, 1, 2, 0);
        add(1, 1, 0, 3, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 3, 0,   0, 0, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; en = vq[i].en; transmiter = vq[i].tx;
            req_len = vq[i].len; clr_cnt = vq[i].clr;
            @(posedge clk); #1;
            chk($sformatf("row%0d recevier", i), int'(recevier), int'(vq[i].rcv));
            chk($sformatf("row%0d busy", i), int'(busy), int'(vq[i].rcv));
            chk($sformatf("row%0d burst_done", i), int'(burst_done), int'(vq[i].done));
            chk($sformatf("row%0d run_len", i), int'(run_len), int'(vq[i].run));
            chk($sformatf("row%0d req_cnt", i), int'(req_cnt), int'(vq[i].req));
            chk($sformatf("row%0d extend_cnt", i), int'(extend_cnt), int'(vq[i].ext));
            chk($sformatf("row%0d burst_cnt", i), int'(burst_cnt), int'(vq[i].bur));
            chk($sformatf("row%0d drop_cnt", i), int'(drop_cnt), int'(vq[i].drp));
        end

        // Saturation: five separate bursts, counters hold at 3.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst = 1'b0; en = 1'b1; transmiter = 1'b1; req_len = 3'd2; clr_cnt = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("sat req_cnt k%0d", k), int'(req_cnt), (k + 1 > 3) ? 3 : k + 1);
            @(negedge clk);
            transmiter = 1'b0;
            repeat (3) @(posedge clk);
        end
        #1;
        chk("sat burst_cnt", int'(burst_cnt), 3);

        // Clear wins over a same-cycle accepted request.
        @(negedge clk);
        clr_cnt = 1'b1; transmiter = 1'b1; req_len = 3'd2;
        @(posedge clk); #1;
        chk("clr req_cnt", int'(req_cnt), 0);
        chk("clr burst_cnt", int'(burst_cnt), 0);
        chk("clr recevier", int'(recevier), 1);
        @(negedge clk);
        clr_cnt = 1'b0; transmiter = 1'b0;
        @(posedge clk); #1;
        chk("clr req_cnt next", int'(req_cnt), 0);
        chk("clr run_len", int'(run_len), 2);
        repeat (3) @(posedge clk);
        #1;
        chk("clr burst_cnt end", int'(burst_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/recevier_burst_gen.md
# recevier_burst_gen

Request-driven response generator that produces the `recevier` strobe consumed by the transmit/receive handshake checker. Every accepted `transmiter` request starts or extends a burst, and `recevier` goes high for a bounded run of consecutive cycles beginning exactly one cycle after the request. Each request therefore satisfies `transmiter |-> ##1 recevier[*MIN_LEN:MAX_LEN]`. The block also keeps saturating handshake statistics and a live run-length count for debug.

## Interface
Parameters:
- `LEN_W`, default 2: width of `req_len`.
- `MIN_LEN`, default 2: minimum burst length in cycles; must be ≥1.
- `MAX_LEN`, default 3: maximum burst length in cycles; must be ≥ `MIN_LEN`.
- `CNT_W`, default 8: width of the statistics counters.

Ports:
- `clk`, in, 1: single clock; all logic is on posedge.
- `rst`, in, 1: reset, synchronous and active-high.
- `en`, in, 1: request enable.
- `transmiter`, in, 1: request, sampled every posedge.
- `req_len`, in, `LEN_W`: requested burst length, sampled together with `transmiter`.
- `clr_cnt`, in, 1: synchronous clear of the statistics counters.
- `recevier`, out, 1: response strobe (registered).
- `busy`, out, 1: high when the state is ACTIVE; identical to `recevier`.
- `burst_done`, out, 1: one-cycle pulse on the first low cycle after a burst.
- `run_len`, out, 4: current consecutive-high count of `recevier`, saturating at 15.
- `req_cnt`, `extend_cnt`, `burst_cnt`, `drop_cnt`, out, `CNT_W` each: saturating statistics counters.

## Operation
- **Effective length:** `L = clamp(req_len, MIN_LEN, MAX_LEN)`. A `req_len` of 0 maps to `MIN_LEN`.
- **Remaining counter:** `rem`, width `$clog2(MAX_LEN+1)`.
  - `rem_dec = (rem != 0) ? rem - 1 : 0`.
  - Accepted request (`transmiter & en`): `rem_next = max(rem_dec, L)`.
  - Otherwise: `rem_next = rem_dec`.
- **States:**
  - IDLE: `rem == 0`.
  - ACTIVE: `rem != 0`.
  - IDLE→ACTIVE on an accepted request.
  - ACTIVE→IDLE when `rem_next == 0`.
  - ACTIVE→ACTIVE otherwise; a new request only extends the burst, it is never queued.
- **`recevier`:** equals `rem != 0`.
- **`burst_done`:** registered; set when `rem == 1` and no request is accepted that cycle.
- **`run_len`:** next value is `sat15(run_len + 1)` if `rem_next != 0`, else 0.
- **Counter increments:** all saturate at `2^CNT_W - 1`.
  - `req_cnt`: every accepted request.
  - `extend_cnt`: accepted request with `rem_dec != 0`.
  - `burst_cnt`: on the same condition that sets `burst_done`.
  - `drop_cnt`: `transmiter & !en`.
- **Clear:** `clr_cnt` zeroes all four counters and wins over a same-cycle increment. It does not affect `rem`, `recevier` or `run_len`.
- **`en` falling mid-burst:** the burst completes normally; only new requests are dropped.

## Timing
- **Reset:** `rst` wins over everything. The cycle after `rst` is sampled high:
  - `rem` = 0, state = IDLE.
  - `recevier`, `busy`, `burst_done` = 0.
  - `run_len` and all counters = 0.
- **Request during reset:** a request sampled in the same cycle as `rst` is ignored and not counted.
- **Reset mid-burst:** `recevier` is low at the next posedge and no `burst_done` pulse is issued.
- **Latency:** a request sampled at posedge t gives `recevier` high at posedges t+1 … t+L, and low at t+L+1 if no further request arrives. `burst_done` is high at t+L+1 only.
- **Back-to-back requests:** N consecutive requests of length L produce one run of N+L-1 high cycles and exactly one `burst_done`.
- **Overlapping request:** a request arriving while `rem_dec >= L` does not lengthen the burst; it is still counted in `extend_cnt`.

## Structure
- Package `resp_pkg` holds:
  - `typedef enum logic {IDLE, ACTIVE} resp_state_t`.
  - A `clamp_len` function.
  - Elaboration-time checks that `MIN_LEN >= 1` and `MIN_LEN <= MAX_LEN`.
- Sub-module `sat_counter #(W)`, with inputs `clk`, `rst`, `clr`, `inc` and output `q`. It is instantiated four times for the statistics counters.
- The top level contains the `rem` datapath, the state register, `run_len` and the `burst_done` register.

## Test plan
The bench binds the property `transmiter |-> ##1 recevier[*2:3]` throughout all scenarios. Clock period is 10.

1. **Single request:** `transmiter=1`, `req_len=2` at posedge 10 only → `recevier` high at 20 and 30, low at 40; `burst_done` high at 40 only; `burst_cnt=1`, `req_cnt=1`, `run_len` peaks at 2.
2. **Length clamping:** `req_len=0` → 2 high cycles; `req_len=3` → 3 high cycles. With `LEN_W=3`, `req_len=7` → 3 high cycles.
3. **Back-to-back:** `transmiter` held high for 3 posedges (10, 20, 30) with `req_len=2` → `recevier` high 20–50, low at 60; `req_cnt=3`, `extend_cnt=2`, `burst_cnt=1`, `run_len` reaches 4.
4. **Enable gating:** `en=0` with a request at 10 → `recevier` stays 0 and `drop_cnt=1`. `en` dropping at 30 during a 3-cycle burst started at 10 → burst still ends at 50.
5. **Reset mid-burst:** request `req_len=3` at 10, `rst` high at 30 → `recevier` 0 at 40, no `burst_done`, all counters 0.
6. **Clear and saturation:** with `CNT_W=2`, 5 single requests → `req_cnt` holds at 3. Then `clr_cnt` and an accepted request in the same cycle → `req_cnt=0` on the next cycle.
